// File: rtl/taxi_axis_frame_trunc.sv
// AXI4-Stream frame length limiter: measures each frame, truncates frames longer
// than a runtime maximum, and reports length/truncation per frame. Registered output + skid.
module taxi_axis_frame_trunc #(
  parameter int                DATA_W               = 64,
  parameter int                KEEP_W               = DATA_W / 8,
  parameter int                ID_W                 = 8,
  parameter int                DEST_W               = 8,
  parameter int                USER_W               = 1,
  parameter int                LEN_W                = 16,
  parameter bit                MARK_TRUNC           = 1'b1,
  parameter logic [USER_W-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_W-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,  // synchronous, active low

  input  logic [DATA_W-1:0] s_axis_tdata_i,
  input  logic [KEEP_W-1:0] s_axis_tkeep_i,
  input  logic [KEEP_W-1:0] s_axis_tstrb_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  input  logic              s_axis_tlast_i,
  input  logic [ID_W-1:0]   s_axis_tid_i,
  input  logic [DEST_W-1:0] s_axis_tdest_i,
  input  logic [USER_W-1:0] s_axis_tuser_i,

  output logic [DATA_W-1:0] m_axis_tdata_o,
  output logic [KEEP_W-1:0] m_axis_tkeep_o,
  output logic [KEEP_W-1:0] m_axis_tstrb_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tlast_o,
  output logic [ID_W-1:0]   m_axis_tid_o,
  output logic [DEST_W-1:0] m_axis_tdest_o,
  output logic [USER_W-1:0] m_axis_tuser_o,

  input  logic [LEN_W-1:0]  cfg_max_len_i,
  output logic              status_valid_o,
  output logic [LEN_W-1:0]  status_len_o,
  output logic              status_trunc_o
);

  localparam int CNT_W = $clog2(KEEP_W + 1);
  localparam int SUM_W = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DISCARD
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [KEEP_W-1:0] strb;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  max_len_q, max_len_d;
  logic              trunc_q, trunc_d;

  beat_t             out_q, out_d;
  logic              out_valid_q, out_valid_d;
  beat_t             skid_q, skid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              s_tready_q, s_tready_d;

  logic              status_valid_q, status_valid_d;
  logic [LEN_W-1:0]  status_len_q, status_len_d;
  logic              status_trunc_q, status_trunc_d;

  logic              s_fire;
  logic [CNT_W-1:0]  beat_bytes;
  logic [LEN_W-1:0]  eff_max;
  logic [SUM_W-1:0]  sum_ext;
  logic [LEN_W-1:0]  cnt_sat;
  logic              over;
  logic [LEN_W-1:0]  remaining;
  logic [KEEP_W-1:0] keep_mask;
  beat_t             in_beat;
  beat_t             emit_beat;
  logic              emit;
  logic              out_free;

  assign s_fire = s_axis_tvalid_i && s_tready_q;

  // Non-contiguous tkeep only skews the count; the control path never depends on it.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + CNT_W'(s_axis_tkeep_i[i]);
    end
  end

  // The first beat of a frame sees the live limit; later beats use the latched copy.
  assign eff_max   = (state_q == ST_IDLE) ? cfg_max_len_i : max_len_q;
  assign sum_ext   = {1'b0, cnt_q} + SUM_W'(beat_bytes);
  assign cnt_sat   = sum_ext[LEN_W] ? {LEN_W{1'b1}} : sum_ext[LEN_W-1:0];
  assign over      = (eff_max != '0) && (sum_ext > {1'b0, eff_max});
  assign remaining = eff_max - cnt_q;

  always_comb begin
    for (int i = 0; i < KEEP_W; i++) begin
      keep_mask[i] = (remaining > LEN_W'(i));
    end
  end

  assign in_beat = '{
    data: s_axis_tdata_i,
    keep: s_axis_tkeep_i,
    strb: s_axis_tstrb_i,
    last: s_axis_tlast_i,
    id:   s_axis_tid_i,
    dest: s_axis_tdest_i,
    user: s_axis_tuser_i
  };

  // A beat arriving when the count already equals the limit masks down to tkeep=0:
  // that is the zero-length end marker for a frame whose last forwarded beat was full.
  always_comb begin
    emit_beat = in_beat;
    if (over) begin
      emit_beat.keep = in_beat.keep & keep_mask;
      emit_beat.last = 1'b1;
      if (MARK_TRUNC) begin
        emit_beat.user = (in_beat.user & ~USER_BAD_FRAME_MASK)
                       | (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    max_len_d      = max_len_q;
    trunc_d        = trunc_q;
    emit           = 1'b0;
    status_valid_d = 1'b0;
    status_len_d   = status_len_q;
    status_trunc_d = status_trunc_q;

    if (s_fire) begin
      unique case (state_q)
        ST_IDLE, ST_PASS: begin
          emit = 1'b1;
          if (state_q == ST_IDLE) begin
            max_len_d = cfg_max_len_i;
          end
          if (s_axis_tlast_i) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            trunc_d        = 1'b0;
            status_valid_d = 1'b1;
            status_len_d   = cnt_sat;
            status_trunc_d = trunc_q || over;
          end else if (over) begin
            state_d = ST_DISCARD;
            cnt_d   = cnt_sat;
            trunc_d = 1'b1;
          end else begin
            state_d = ST_PASS;
            cnt_d   = cnt_sat;
          end
        end
        ST_DISCARD: begin
          if (s_axis_tlast_i) begin
            state_d        = ST_IDLE;
            cnt_d          = '0;
            trunc_d        = 1'b0;
            status_valid_d = 1'b1;
            status_len_d   = cnt_sat;
            status_trunc_d = trunc_q;
          end else begin
            cnt_d = cnt_sat;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // An emitted beat only exists while the skid is empty (tready is low otherwise,
  // except in DISCARD where nothing is emitted), so skid and new beat never collide.
  assign out_free = !out_valid_q || m_axis_tready_i;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (emit) begin
        out_d       = emit_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (emit) begin
      skid_d       = emit_beat;
      skid_valid_d = 1'b1;
    end

    s_tready_d = !skid_valid_d || (state_d == ST_DISCARD);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      max_len_q      <= '0;
      trunc_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      skid_valid_q   <= 1'b0;
      s_tready_q     <= 1'b0;
      status_valid_q <= 1'b0;
      status_len_q   <= '0;
      status_trunc_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      max_len_q      <= max_len_d;
      trunc_q        <= trunc_d;
      out_valid_q    <= out_valid_d;
      skid_valid_q   <= skid_valid_d;
      s_tready_q     <= s_tready_d;
      status_valid_q <= status_valid_d;
      status_len_q   <= status_len_d;
      status_trunc_q <= status_trunc_d;
    end
  end

  // NOTE: beat payload registers are not reset; their valid flags qualify them.
  always_ff @(posedge clk_i) begin
    out_q  <= out_d;
    skid_q <= skid_d;
  end

  assign s_axis_tready_o = s_tready_q;

  assign m_axis_tdata_o  = out_q.data;
  assign m_axis_tkeep_o  = out_q.keep;
  assign m_axis_tstrb_o  = out_q.strb;
  assign m_axis_tvalid_o = out_valid_q;
  assign m_axis_tlast_o  = out_q.last;
  assign m_axis_tid_o    = out_q.id;
  assign m_axis_tdest_o  = out_q.dest;
  assign m_axis_tuser_o  = out_q.user;

  assign status_valid_o  = status_valid_q;
  assign status_len_o    = status_len_q;
  assign status_trunc_o  = status_trunc_q;

endmodule

// File: tb/tb_taxi_axis_frame_trunc.sv
// Scoreboard bench for taxi_axis_frame_trunc: a frame-level truncation model fills
// expected-beat and expected-status queues as frames are driven; monitors pop and compare.
module tb_taxi_axis_frame_trunc;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic [0:0]  user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic [7:0]  s_tstrb = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  s_tid = '0;
  logic [7:0]  s_tdest = '0;
  logic [0:0]  s_tuser = '0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [7:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [7:0]  m_tid;
  logic [7:0]  m_tdest;
  logic [0:0]  m_tuser;
  logic [15:0] cfg_max_len = '0;
  logic        status_valid;
  logic [15:0] status_len;
  logic        status_trunc;

  taxi_axis_frame_trunc #(
    .DATA_W(64), .KEEP_W(8), .ID_W(8), .DEST_W(8), .USER_W(1), .LEN_W(16),
    .MARK_TRUNC(1'b1), .USER_BAD_FRAME_VALUE(1'b1), .USER_BAD_FRAME_MASK(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tstrb_i(s_tstrb),
    .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready), .s_axis_tlast_i(s_tlast),
    .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_tdest), .s_axis_tuser_i(s_tuser),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tstrb_o(m_tstrb),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready), .m_axis_tlast_o(m_tlast),
    .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest), .m_axis_tuser_o(m_tuser),
    .cfg_max_len_i(cfg_max_len),
    .status_valid_o(status_valid), .status_len_o(status_len), .status_trunc_o(status_trunc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_accept_cyc = 0;
  int          stalls = 0;
  bit          lat_check = 1'b0;
  bit          thru_mon = 1'b0;
  bit          rand_ready = 1'b0;
  beat_t       exp_q[$];
  logic [16:0] stat_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_tready = ($urandom_range(0, 99) < 30);
    end
  end

  // Output and status monitors sample mid-cycle; a handshake seen here completes next edge.
  always @(negedge clk) begin
    beat_t       e;
    logic [16:0] st;
    if (rst_n && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("m_unexpected_beat", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("m_tdata", m_tdata, e.data);
        check("m_tkeep", 64'(m_tkeep), 64'(e.keep));
        check("m_tstrb", 64'(m_tstrb), 64'(e.strb));
        check("m_tlast", 64'(m_tlast), 64'(e.last));
        check("m_tid",   64'(m_tid),   64'(e.id));
        check("m_tdest", 64'(m_tdest), 64'(e.dest));
        check("m_tuser", 64'(m_tuser), 64'(e.user));
        if (lat_check) check("m_latency", 64'(cyc), 64'(last_accept_cyc));
      end
    end
    if (rst_n && status_valid) begin
      if (stat_q.size() == 0) begin
        check("status_unexpected", 64'd0, 64'd1);
      end else begin
        st = stat_q.pop_front();
        check("status_len",   64'(status_len),   64'(st[15:0]));
        check("status_trunc", 64'(status_trunc), 64'(st[16]));
      end
    end
    if (thru_mon && s_tvalid && !s_tready) stalls++;
  end

  task automatic model_frame(input beat_t frm[$], input logic [15:0] max);
    int unsigned cnt = 0;
    int unsigned n;
    int unsigned rem;
    bit          trunc = 1'b0;
    bit          disc = 1'b0;
    beat_t       b;
    foreach (frm[i]) begin
      b = frm[i];
      n = $countones(b.keep);
      if (!disc) begin
        if (max != 0 && cnt + n > max) begin
          rem    = max - cnt;
          b.keep = b.keep & 8'((32'd1 << rem) - 1);
          b.last = 1'b1;
          b.user = 1'b1;
          trunc  = 1'b1;
          disc   = 1'b1;
        end
        exp_q.push_back(b);
      end
      cnt = cnt + n;
      if (cnt > 65535) cnt = 65535;
    end
    stat_q.push_back({trunc, 16'(cnt)});
  endtask

  task automatic mk_frame(input int nb, input int last_bytes, input bit rnd, output beat_t q[$]);
    beat_t b;
    q = {};
    for (int i = 0; i < nb; i++) begin
      b.data = {$urandom(), $urandom()};
      b.keep = (i == nb - 1) ? 8'((16'd1 << last_bytes) - 1) : 8'hFF;
      b.strb = b.keep;
      b.last = (i == nb - 1);
      b.id   = 8'($urandom());
      b.dest = 8'($urandom());
      b.user = rnd ? 1'($urandom()) : 1'b0;
      q.push_back(b);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic drive_beat(input beat_t b);
    bit acc;
    bit done = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = b.data;
    s_tkeep  = b.keep;
    s_tstrb  = b.strb;
    s_tlast  = b.last;
    s_tid    = b.id;
    s_tdest  = b.dest;
    s_tuser  = b.user;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
        last_accept_cyc = cyc;
      end
    end
    if (!done) check("s_accept_timeout", 64'd0, 64'd1);
  endtask

  // The limit is perturbed after the first beat; the block must keep the latched value.
  task automatic send_frame(input beat_t frm[$], input logic [15:0] max);
    model_frame(frm, max);
    cfg_max_len = max;
    foreach (frm[i]) begin
      drive_beat(frm[i]);
      if (i == 0) cfg_max_len = max ^ 16'h0003;
    end
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    s_tvalid = 1'b0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("drain_beats_left", 64'(exp_q.size()), 64'd0);
    check("drain_status_left", 64'(stat_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t       frm[$];
    beat_t       b;
    logic [15:0] maxes[8] = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd16, 16'd20, 16'd24, 16'd40};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_status_valid", 64'(status_valid), 64'd0);
    check("rst_status_len", 64'(status_len), 64'd0);
    check("rst_status_trunc", 64'(status_trunc), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready", 64'(s_tready), 64'd1);

    lat_check = 1'b1;
    // Pass-through, no limit: 8+8+4 = 20 bytes
    mk_frame(3, 4, 1'b0, frm);
    send_frame(frm, 16'd0);
    wait_drain(100);
    // Limit 12 on 4 full beats: 0xFF, then 0x0F marked, rest dropped, len 32
    mk_frame(4, 8, 1'b0, frm);
    send_frame(frm, 16'd12);
    wait_drain(100);
    // Limit 16 on 3 full beats: two full beats then zero-length marker, len 24
    mk_frame(3, 8, 1'b0, frm);
    send_frame(frm, 16'd16);
    wait_drain(100);
    // Limit 16 on 2 full beats: exact fit, untouched
    mk_frame(2, 8, 1'b0, frm);
    send_frame(frm, 16'd16);
    wait_drain(100);

    // Back-to-back frames with tready held high: no input stall allowed
    thru_mon = 1'b1;
    for (int f = 0; f < 8; f++) begin
      mk_frame($urandom_range(1, 5), $urandom_range(1, 8), 1'b1, frm);
      send_frame(frm, maxes[$urandom_range(0, 7)]);
    end
    thru_mon = 1'b0;
    wait_drain(200);
    check("throughput_stalls", 64'(stalls), 64'd0);

    // Random 30% output ready, back-to-back frames
    lat_check  = 1'b0;
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      mk_frame($urandom_range(1, 6), $urandom_range(1, 8), 1'b1, frm);
      send_frame(frm, maxes[$urandom_range(0, 7)]);
    end
    wait_drain(3000);
    rand_ready = 1'b0;
    m_tready   = 1'b1;

    // Length saturation: 8200 full beats exceed 2^16-1 bytes
    lat_check = 1'b1;
    mk_frame(8200, 8, 1'b0, frm);
    send_frame(frm, 16'd0);
    wait_drain(200);

    // Reset while discarding; the frame is abandoned and reports nothing
    mk_frame(6, 8, 1'b0, frm);
    b      = frm[0];
    b.keep = 8'h0F;
    b.last = 1'b1;
    b.user = 1'b1;
    exp_q.push_back(b);
    cfg_max_len = 16'd4;
    drive_beat(frm[0]);
    drive_beat(frm[1]);
    drive_beat(frm[2]);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_status_valid", 64'(status_valid), 64'd0);
    check("midrst_beats_left", 64'(exp_q.size()), 64'd0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mk_frame(3, 5, 1'b0, frm);
    send_frame(frm, 16'd0);
    wait_drain(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=0", 1);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/taxi_axis_frame_trunc.md
Name: taxi_axis_frame_trunc

Overview:
- Single-clock AXI4-Stream stage placed directly downstream of the async FIFO/width-adapter output, in the m_clk domain.
- Measures each frame's byte length and truncates frames longer than a runtime maximum; truncated frames are optionally marked bad.
- Reports per-frame length and a truncation flag.
- Registered output with a skid buffer: full throughput, no combinational tready path.

Parameters:
- LEN_W, 16: width of the length counter, cfg_max_len and status_len.
- MARK_TRUNC, 1: when 1, tuser is forced on the truncated final beat.
- USER_BAD_FRAME_VALUE, 1'b1: tuser value written on a truncated frame's last beat.
- USER_BAD_FRAME_MASK, 1'b1: tuser bits affected by marking.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset. Asserted when rst=0 at a clk edge.
- s_axis, taxi_axis_if.snk, -: input stream. KEEP_EN and LAST_EN are required. s and m interface parameters are identical.
- m_axis, taxi_axis_if.src, -: output stream.
- cfg_max_len, input, LEN_W: maximum frame length in bytes. 0 disables truncation.
- status_valid, output, 1: single-cycle pulse when a frame's last beat is accepted on s_axis.
- status_len, output, LEN_W: byte length of the input frame, saturating.
- status_trunc, output, 1: the frame was truncated. Qualified by status_valid.

Behaviour:
- Beat byte count:
  - popcount(tkeep) of the accepted s_axis beat.
  - tkeep is required to be contiguous from bit 0. Non-contiguous tkeep gives undefined length but must not hang the block.
- Length counter:
  - Accumulates beat byte counts; saturates at 2^LEN_W-1.
  - Clears after the beat with tlast is accepted.
- Max-length latch: cfg_max_len is latched at the first beat of each frame. Changes mid-frame have no effect until the next frame.
- State machine:
  - IDLE: no frame in progress. First accepted beat moves to PASS, or straight back to IDLE if tlast=1.
  - PASS: beats are forwarded unchanged. On a beat where count_before + beat_bytes > max_len (max_len != 0):
    - Forward the beat with tkeep masked to the low (max_len - count_before) bytes and tlast forced to 1.
    - If MARK_TRUNC, tuser = (tuser & ~MASK) | (VALUE & MASK).
    - Go to DISCARD if input tlast=0, else IDLE.
    - A beat that lands exactly on max_len is not truncated.
  - DISCARD: s_axis.tready=1 regardless of output state. Beats are dropped and still counted into status_len. On tlast go to IDLE.
- Special case, count_before == max_len: the previous beat was exactly full and input continues. That beat was already forwarded without tlast, so the block emits a zero-length marker beat: tkeep=0, tlast=1, tuser marked. This applies equally at frame start when max_len=0 is not in use, i.e. it is never reached from IDLE.
- Status outputs:
  - status_valid pulses the cycle after the input tlast beat is accepted, including in DISCARD.
  - status_len equals the full input length.
  - status_trunc=1 if truncation occurred in the frame.
- Output path:
  - 1-cycle latency from s accept to m_axis.tvalid.
  - Output register plus a one-entry skid buffer.
  - s_axis.tready is registered: high when the skid buffer is empty, or when in DISCARD.
  - tdata, tid, tdest and tstrb pass through unmodified.
- Backpressure: m_axis.tready low holds all output fields stable while tvalid is high (AXI rule). No beat is lost or duplicated.
- Reset (rst=0):
  - m_axis.tvalid=0, s_axis.tready=0 during reset, then 1 the first cycle after.
  - State returns to IDLE, counter=0, status_valid=0, status_len=0, status_trunc=0, skid buffer emptied.
  - Reset mid-frame abandons the frame. The next beat after reset is treated as a frame start.
- Simultaneous events: a frame-end beat and the next frame's first beat on consecutive cycles must both be processed with no bubble.

Test Plan (DATA_W=64, KEEP_W=8, LEN_W=16):
- cfg_max_len=0, 3-beat frame, last tkeep=0x0F -> output identical to input, status_len=20, status_trunc=0, 1-cycle latency.
- cfg_max_len=12, frame of 4 full beats -> output beat 1 tkeep=0xFF, beat 2 tkeep=0x0F with tlast=1 and tuser=1; remaining 2 beats dropped; status_len=32, status_trunc=1.
- cfg_max_len=16, 3 full beats -> beats 1 and 2 forwarded (beat 2 tlast=0), then marker beat tkeep=0x00, tlast=1, tuser=1; status_len=24, status_trunc=1.
- cfg_max_len=16, 2 full beats -> exact fit, untruncated, tuser unchanged, status_trunc=0.
- Random m_axis.tready at 30% duty with back-to-back frames -> scoreboard matches the truncation model; no loss or duplication; full throughput when tready=1.
- Assert rst=0 mid-frame during DISCARD, release -> tvalid=0 during reset; the next frame passes intact; no stale status_valid.
